// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//
// Contents:
//   state_e : controller state encoding (2'b11 is unused and recovers to ST_IDLE)
//   clog2   : ceiling log2, used to size the bit counter from WIDTH
package serial_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Elaboration-time ceiling log2; value 1 yields 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder built from two half adders.
//
// Ports:
//   a, b  : addend bits
//   c     : carry in
//   s     : sum bit
//   cout  : carry out
module fa (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic cout
);

   logic ha0_s;
   logic ha0_c;
   logic ha1_c;

   // First half adder: a + b
   assign ha0_s = a ^ b;
   assign ha0_c = a & b;

   // Second half adder: (a ^ b) + c
   assign s     = ha0_s ^ c;
   assign ha1_c = ha0_s & c;

   assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. One fa cell is sequenced LSB-first over WIDTH
// cycles to form a + b + cin, producing sum, carry-out and signed overflow.
//
// Ports:
//   clk, rst_n           : clock and synchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin sampled on accept)
//   out_valid / out_ready: result handshake (sum, cout, ovf held while waiting)
//   busy                 : controller is in RUN or DONE
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned      CNT_W    = clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pre_msb_carry_q, pre_msb_carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             fa_s;
   logic             fa_cout;

   // The only adder in the datapath: one bit slice per RUN cycle.
   fa u_fa (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .c    (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   always_comb begin
      state_d         = state_q;
      a_sr_d          = a_sr_q;
      b_sr_d          = b_sr_q;
      sum_sr_d        = sum_sr_q;
      carry_d         = carry_q;
      cnt_d           = cnt_q;
      pre_msb_carry_d = pre_msb_carry_q;
      sum_d           = sum_q;
      cout_d          = cout_q;
      ovf_d           = ovf_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            // Sum bits enter at the MSB so that after WIDTH shifts bit 0 is the LSB.
            sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            carry_d  = fa_cout;
            cnt_d    = cnt_q + CNT_W'(1);

            // Carry out of bit WIDTH-2 is the carry into the MSB.
            if (cnt_q == CNT_PRE) begin
               pre_msb_carry_d = fa_cout;
            end

            if (cnt_q == CNT_LAST) begin
               sum_d   = sum_sr_d;
               cout_d  = fa_cout;
               ovf_d   = pre_msb_carry_q ^ fa_cout;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         a_sr_q          <= '0;
         b_sr_q          <= '0;
         sum_sr_q        <= '0;
         carry_q         <= 1'b0;
         cnt_q           <= '0;
         pre_msb_carry_q <= 1'b0;
         sum_q           <= '0;
         cout_q          <= 1'b0;
         ovf_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         a_sr_q          <= a_sr_d;
         b_sr_q          <= b_sr_d;
         sum_sr_q        <= sum_sr_d;
         carry_q         <= carry_d;
         cnt_q           <= cnt_d;
         pre_msb_carry_q <= pre_msb_carry_d;
         sum_q           <= sum_d;
         cout_q          <= cout_d;
         ovf_q           <= ovf_d;
      end
   end

   // in_ready drops combinationally while reset is held.
   assign in_ready  = rst_n && (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: sequences a single existing `fa` full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands plus carry-in.
- Operands come in on a valid/ready handshake; results go out on a valid/ready handshake.
- Used wherever area matters more than throughput: one full-adder instance replaces a WIDTH-bit ripple adder.
- Holds a carry flop and shift registers; produces sum, carry-out and signed-overflow.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operand bundle valid
- in_ready  output  1  controller can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result bits
- cout  output  1  carry out of MSB
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). It is sampled only on rising clk.
- While rst_n is low, in_ready is forced to 0.
- At the first edge with rst_n low, all state is cleared:
  - state = IDLE
  - out_valid = 0, sum = 0, cout = 0, ovf = 0, busy = 0
  - carry flop = 0, counter = 0
- After reset releases: in_ready = 1.
- FSM states (2-bit):
  - IDLE: in_ready = 1. On in_valid at an edge: load a_sr = a, b_sr = b, carry = cin, cnt = 0; go to RUN.
  - RUN: in_ready = 0. Each edge:
    - Drive fa inputs a = a_sr[0], b = b_sr[0], c = carry.
    - sum_sr <= {fa.s, sum_sr[WIDTH-1:1]}.
    - a_sr and b_sr shift right by 1.
    - carry <= fa.cout, cnt <= cnt + 1.
    - When cnt == WIDTH-2: capture pre_msb_carry <= fa.cout (the carry into the MSB).
    - When cnt == WIDTH-1: go to DONE. On this same edge, register sum = final sum_sr, cout = fa.cout, ovf = pre_msb_carry XOR fa.cout.
  - DONE: out_valid = 1. sum, cout and ovf are held stable until an edge with out_ready = 1; then go to IDLE and out_valid = 0 on the next cycle.
- Latency: accept at edge k → out_valid high in the cycle after edge k+WIDTH (WIDTH cycles). Throughput: one operation per WIDTH+2 cycles minimum.
- Handshake rules:
  - Transfer occurs only on edges where valid & ready are both high.
  - in_valid while in RUN or DONE is ignored (no capture, no queuing).
  - out_ready while in IDLE or RUN has no effect.
  - a, b and cin are sampled only on the accept edge; changes afterwards do not affect the result.
- sum, cout and ovf keep their last values in IDLE until the next DONE update. They are cleared only by reset.
- Reset mid-operation (RUN or DONE): the result is discarded; next cycle the state is IDLE with all outputs at reset values. No partial result is ever presented.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin. ovf is the two's-complement overflow of the same addition.
- busy = (state != IDLE).

Decomposition:
- Shared package `serial_add_pkg`:
  - State encodings: ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_DONE = 2'b10. 2'b11 is illegal and recovers to IDLE.
  - Function clog2 for CNT_W.
- Exactly one sub-module: the existing `fa` (full adder built from two half adders), instantiated once as the serial bit-slice.
- No other arithmetic is inferred in the datapath; only the counter increment is.

Test Plan (WIDTH=8):
- Accept a=8'h35, b=8'h4A, cin=0 → out_valid rises exactly 8 cycles after the accept edge; sum=8'h7F, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0; a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1.
- a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1, ovf=0; a=8'h80, b=8'h80, cin=0 → sum=8'h00, cout=1, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE → out_valid and sum/cout/ovf stay constant. Toggle in_valid with new operands during RUN/DONE → in_ready=0 and the result is unaffected. On out_ready=1, IDLE follows and in_ready=1 next cycle.
- Assert rst_n=0 for one edge at RUN cycle 3 → next cycle state is IDLE, out_valid=0, sum=0, busy=0. A subsequent a=8'h10, b=8'h20 → sum=8'h30.
- Back-to-back: in_valid held high with out_ready tied high → one accept every 10 cycles; 256 random operand pairs are checked against a reference a+b+cin model.
